uart_cmd_link: RTL
==================

Name: uart_cmd_link

Overview:
Host-side front end for the command/response handshake consumed by the command-configuration FSM.
- Command path: assembles three bytes from the existing UART receiver into a 24-bit command, then presents it with cmd_rdy until cleared.
- Response path: accepts a one-byte response request, drives the UART transmitter, and reports completion with a resp_sent pulse.
- Sits between the UART rx/tx cores and the command-configuration FSM.

Parameters:
TIMEOUT_CYC, 1_000_000, inter-byte timeout in clk cycles (20 ms at 50 MHz); partially assembled commands are discarded when it expires.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  UART receiver holds a byte (level)
rx_data  in  8  received byte
clr_rx_rdy  out  1  one-cycle pulse: byte consumed
trmt  out  1  one-cycle pulse: start UART transmit
tx_data  out  8  byte to transmit
tx_done  in  1  one-cycle pulse: UART transmit complete
cmd  out  24  assembled command; byte 1 in [23:16], byte 3 in [7:0]
cmd_rdy  out  1  cmd valid (level)
clr_cmd_rdy  in  1  consumer done with cmd
resp_data  in  8  response byte
send_resp  in  1  one-cycle pulse: transmit resp_data
resp_sent  out  1  one-cycle pulse: response fully transmitted
ovr_flags  out  2  sticky; [0] = rx byte dropped while cmd_rdy, [1] = send_resp while tx busy
clr_ovr  in  1  clears ovr_flags

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk. All outputs reset to 0 (cmd 24'h000000, tx_data 8'h00). Both FSMs reset to their idle states. The timeout counter resets to 0.
- All outputs are registered except clr_rx_rdy, which is combinational from the state and rx_rdy.
- RX FSM states:
  - R_B1: when rx_rdy=1, assert clr_rx_rdy, load cmd[23:16]<=rx_data, go to R_B2.
  - R_B2: when rx_rdy=1, assert clr_rx_rdy, load cmd[15:8], go to R_B3.
  - R_B3: when rx_rdy=1, assert clr_rx_rdy, load cmd[7:0], set cmd_rdy, go to R_HOLD.
  - R_HOLD: cmd_rdy=1; on clr_cmd_rdy, clear cmd_rdy and go to R_B1.
- Latency: if the third byte is consumed in cycle N, cmd_rdy=1 and cmd is valid after the clock edge ending cycle N.
- cmd is stable for the whole time cmd_rdy=1. It is not cleared when the consumer clears cmd_rdy.
- Timeout:
  - The counter resets to 0 on every consumed byte and in R_B1/R_HOLD; it increments in R_B2/R_B3.
  - When it reaches TIMEOUT_CYC-1, go to R_B1 and discard the partial bytes. cmd_rdy stays 0.
  - If a byte and the timeout coincide, the byte wins: it is consumed and the state advances.
- rx_rdy in R_HOLD: the byte is consumed (clr_rx_rdy pulses) and discarded, and ovr_flags[0] is set.
- clr_cmd_rdy and rx_rdy in the same R_HOLD cycle: the clear wins. The byte is not consumed in that cycle; it is taken as byte 1 in R_B1 on the next cycle. ovr_flags[0] is not set.
- clr_cmd_rdy outside R_HOLD is ignored.
- TX FSM states:
  - T_IDLE: when send_resp=1, latch tx_data<=resp_data, pulse trmt on the next cycle, go to T_BUSY.
  - T_BUSY: when tx_done=1, pulse resp_sent for one cycle (the cycle after tx_done), go to T_IDLE.
- send_resp in T_BUSY is ignored: tx_data is unchanged and ovr_flags[1] is set.
- tx_done in T_IDLE is ignored.
- send_resp in the same cycle that T_BUSY sees tx_done is treated as busy (ignored, flag set).
- The RX and TX FSMs are independent. Commands may be assembled while a response is transmitting.
- ovr_flags: a set and clr_ovr in the same cycle leaves the flag set.
- Reset mid-operation: any partial command, pending trmt or pending resp_sent is abandoned; no pulse follows reset.

Decomposition:
- Package uart_link_pkg holds:
  - typedefs rx_state_t and tx_state_t;
  - constants CMD_BYTES=3, RESP_ACK=8'hA5, RESP_NAK=8'hEE.
- One sub-module, uart_resp_tx: the TX FSM, tx_data latch and ovr_flags[1]. The top level holds the RX FSM, timeout counter and ovr_flags[0].

Test Plan:
- Bytes 8'h02, 8'h0D, 8'h00 with 3-cycle gaps -> exactly three clr_rx_rdy pulses; cmd=24'h020D00 and cmd_rdy=1 one cycle after the third consume; cmd_rdy held until clr_cmd_rdy, then 0 next cycle.
- Bytes 8'h09, 8'h05, then idle for TIMEOUT_CYC cycles (bench overrides to 16), then 8'h04, 8'h01, 8'hFF -> cmd=24'h0401FF; the 8'h09/8'h05 partial never appears on cmd.
- With cmd_rdy=1, present 8'hAA -> clr_rx_rdy pulses, cmd unchanged, ovr_flags=2'b01. Then clr_cmd_rdy together with rx_rdy (8'h07) -> no consume that cycle; 8'h07 consumed next cycle into cmd[23:16]; ovr_flags[0] not set by this byte.
- send_resp with resp_data=8'hA5 -> tx_data=8'hA5 and a one-cycle trmt. A second send_resp with 8'hEE while busy -> tx_data stays 8'hA5, ovr_flags[1]=1. tx_done -> resp_sent pulses exactly once, the next cycle.
- Assert rst_n=0 after byte 2 of a command and while a transmit is in T_BUSY -> all outputs 0. Then a full 8'h07, 8'h00, 8'h00 -> cmd=24'h070000 with no stale bytes, and no spurious resp_sent.

Source files
------------

// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared types and constants for the UART command link
package uart_link_pkg;

    typedef enum logic [1:0] {
        R_B1   = 2'd0,
        R_B2   = 2'd1,
        R_B3   = 2'd2,
        R_HOLD = 2'd3
    } rx_state_t;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_BUSY = 1'b1
    } tx_state_t;

    localparam int         CMD_BYTES = 3;
    localparam int         CMD_W     = CMD_BYTES * 8;
    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NAK  = 8'hEE;

endpackage

// File: rtl/uart_cmd_link_if.sv
// rtl/uart_cmd_link_if.sv - UART-side and consumer-side signals of the command link
interface uart_cmd_link_if;
    import uart_link_pkg::*;

    logic             rx_rdy;
    logic [7:0]       rx_data;
    logic             clr_rx_rdy;
    logic             trmt;
    logic [7:0]       tx_data;
    logic             tx_done;
    logic [CMD_W-1:0] cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic [7:0]       resp_data;
    logic             send_resp;
    logic             resp_sent;
    logic [1:0]       ovr_flags;
    logic             clr_ovr;

    modport master (
        input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, resp_data, send_resp, clr_ovr,
        output clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent, ovr_flags
    );

    modport slave (
        output rx_rdy, rx_data, tx_done, clr_cmd_rdy, resp_data, send_resp, clr_ovr,
        input  clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent, ovr_flags
    );

endinterface

// File: rtl/uart_resp_tx.sv
// rtl/uart_resp_tx.sv - response transmit FSM with tx_data latch and busy-overrun flag
module uart_resp_tx
    import uart_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp_data,
    input  logic       tx_done,
    input  logic       clr_ovr,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent,
    output logic       ovr_tx
);

    tx_state_t  state_q, state_d;
    logic [7:0] tx_data_d;
    logic       trmt_d;
    logic       resp_sent_d;
    logic       ovr_set;

    // State and output registers; reset abandons any pending trmt or resp_sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= T_IDLE;
            tx_data   <= 8'h00;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            ovr_tx    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data   <= tx_data_d;
            trmt      <= trmt_d;
            resp_sent <= resp_sent_d;
            ovr_tx    <= ovr_set | (ovr_tx & ~clr_ovr);
        end
    end

    // Next state: a request while busy (even on the tx_done cycle) is dropped and flagged.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        ovr_set     = 1'b0;
        case (state_q)
            T_IDLE: begin
                if (send_resp) begin
                    tx_data_d = resp_data;
                    trmt_d    = 1'b1;
                    state_d   = T_BUSY;
                end
            end
            T_BUSY: begin
                if (send_resp) begin
                    ovr_set = 1'b1;
                end
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    state_d     = T_IDLE;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_link.sv
// rtl/uart_cmd_link.sv - three-byte command assembler with timeout plus response transmitter
module uart_cmd_link
    import uart_link_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_cmd_link_if.master  bus
);

    localparam int            TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    rx_state_t        rx_q, rx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [15:0]      asm_q, asm_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             ovr_rx_q;
    logic             ovr_rx_set;
    logic             consume;
    logic             ovr_tx;

    // RX state, timeout counter, partial bytes and the published command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q      <= R_B1;
            tmo_q     <= '0;
            asm_q     <= 16'h0000;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            ovr_rx_q  <= 1'b0;
        end else begin
            rx_q      <= rx_d;
            tmo_q     <= tmo_d;
            asm_q     <= asm_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            ovr_rx_q  <= ovr_rx_set | (ovr_rx_q & ~bus.clr_ovr);
        end
    end

    // Bytes 1-2 collect in a shadow register so a timed-out partial never reaches cmd.
    always_comb begin
        rx_d       = rx_q;
        tmo_d      = tmo_q;
        asm_d      = asm_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        consume    = 1'b0;
        ovr_rx_set = 1'b0;
        case (rx_q)
            R_B1: begin
                tmo_d = '0;
                if (bus.rx_rdy) begin
                    consume     = 1'b1;
                    asm_d[15:8] = bus.rx_data;
                    rx_d        = R_B2;
                end
            end
            R_B2, R_B3: begin
                if (bus.rx_rdy) begin
                    consume = 1'b1;
                    tmo_d   = '0;
                    if (rx_q == R_B2) begin
                        asm_d[7:0] = bus.rx_data;
                        rx_d       = R_B3;
                    end else begin
                        cmd_d     = {asm_q, bus.rx_data};
                        cmd_rdy_d = 1'b1;
                        rx_d      = R_HOLD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d = '0;
                    asm_d = 16'h0000;
                    rx_d  = R_B1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            R_HOLD: begin
                tmo_d = '0;
                if (bus.clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    rx_d      = R_B1;
                end else if (bus.rx_rdy) begin
                    consume    = 1'b1;
                    ovr_rx_set = 1'b1;
                end
            end
            default: rx_d = R_B1;
        endcase
    end

    assign bus.clr_rx_rdy = consume;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.ovr_flags  = {ovr_tx, ovr_rx_q};

    uart_resp_tx u_resp_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (bus.send_resp),
        .resp_data (bus.resp_data),
        .tx_done   (bus.tx_done),
        .clr_ovr   (bus.clr_ovr),
        .trmt      (bus.trmt),
        .tx_data   (bus.tx_data),
        .resp_sent (bus.resp_sent),
        .ovr_tx    (ovr_tx)
    );

endmodule
